// File: rtl/t02_regfile_pkg.sv
// Shared constants for the register file and its busy scoreboard.
package t02_regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_IDX     = 0;
endpackage

// File: rtl/t02_busy_scoreboard.sv
// Per-register pending-write tracker: set by issuing producers, cleared by
// writeback or flush, with per-port lookup that honours same-cycle writeback.
module t02_busy_scoreboard
  import t02_regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_idx,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_idx,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wr_ok, set_ok;

  function automatic logic idx_ok(logic [ADDR_W-1:0] i);
    return (i != ADDR_W'(ZERO_IDX)) && (32'(i) < 32'(NUM_REGS));
  endfunction

  assign wr_ok  = nRST && wr_en && idx_ok(wr_idx);
  assign set_ok = nRST && set_en && idx_ok(set_idx);

  // Order matters: flush, then writeback clear, then set (newest producer wins).
  always_comb begin
    busy_d = busy_q;
    if (flush) busy_d = '0;
    if (wr_ok) busy_d[wr_idx] = 1'b0;
    if (set_ok) busy_d[set_idx] = 1'b1;
    busy_d[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nRST) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign any_busy = nRST && (|busy_q);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              lane_busy;
    assign idx = rd_idx[k*ADDR_W +: ADDR_W];
    always_comb begin
      lane_busy = 1'b0;
      if (nRST && idx_ok(idx)) begin
        if ((BYPASS != 0) && wr_ok && (wr_idx == idx)) lane_busy = 1'b0;
        else                                           lane_busy = busy_q[idx];
      end
    end
    assign rd_busy[k] = lane_busy;
  end

endmodule

// File: rtl/t02_regfile_scoreboard.sv
// Register file with hard-wired zero register, NUM_RD combinational read
// ports, optional writeback bypass and a busy scoreboard for decode stalls.
module t02_regfile_scoreboard
  import t02_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_index,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_index,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_index,
  input  logic                     flush,
  output logic                     any_busy
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                            wr_ok;

  function automatic logic idx_ok(logic [ADDR_W-1:0] i);
    return (i != ADDR_W'(ZERO_IDX)) && (32'(i) < 32'(NUM_REGS));
  endfunction

  assign wr_ok = nRST && reg_write && idx_ok(write_index);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[write_index] = write_data;
    regs_d[ZERO_IDX] = '0;
  end

  always_ff @(posedge clk) begin
    if (!nRST) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] lane_data;
    assign idx = read_index[k*ADDR_W +: ADDR_W];
    // Reads are held at zero while reset is asserted, bypass included.
    always_comb begin
      lane_data = '0;
      if (nRST && idx_ok(idx)) begin
        if ((BYPASS != 0) && wr_ok && (write_index == idx)) lane_data = write_data;
        else                                                lane_data = regs_q[idx];
      end
    end
    assign read_data[k*DATA_W +: DATA_W] = lane_data;
  end

  t02_busy_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .BYPASS  (BYPASS)
  ) u_busy (
    .clk     (clk),
    .nRST    (nRST),
    .wr_en   (reg_write),
    .wr_idx  (write_index),
    .set_en  (busy_set),
    .set_idx (busy_index),
    .flush   (flush),
    .rd_idx  (read_index),
    .rd_busy (read_busy),
    .any_busy(any_busy)
  );

endmodule

// File: tb/tb_t02_regfile_scoreboard.sv
// Directed bench: bypassing 4-port/32-reg instance and a non-bypassing
// 1-port/20-reg instance share stimulus; expectations are queued and checked.
module tb_t02_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        nrst;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic [19:0] read_index;
  logic        busy_set;
  logic [4:0]  busy_index;
  logic        flush;

  logic [127:0] rd_a;
  logic [3:0]   bz_a;
  logic         any_a;
  logic [31:0]  rd_b;
  logic [0:0]   bz_b;
  logic         any_b;

  always #5 clk = ~clk;

  t02_regfile_scoreboard #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4), .BYPASS(1)) dut_a (
    .clk(clk), .nRST(nrst), .reg_write(reg_write), .write_index(write_index),
    .write_data(write_data), .read_index(read_index), .read_data(rd_a),
    .read_busy(bz_a), .busy_set(busy_set), .busy_index(busy_index),
    .flush(flush), .any_busy(any_a)
  );

  t02_regfile_scoreboard #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(1), .BYPASS(0)) dut_b (
    .clk(clk), .nRST(nrst), .reg_write(reg_write), .write_index(write_index),
    .write_data(write_data), .read_index(read_index[4:0]), .read_data(rd_b),
    .read_busy(bz_b), .busy_set(busy_set), .busy_index(busy_index),
    .flush(flush), .any_busy(any_b)
  );

  typedef struct {
    string       nm;
    bit          on_b;
    int          port;
    logic [31:0] data;
    logic        busy;
    logic        any;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // Monitor: everything queued during a cycle is compared at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] gd;
      logic        gb, ga;
      e = q.pop_front();
      if (e.on_b) begin gd = rd_b; gb = bz_b[0]; ga = any_b; end
      else begin gd = rd_a[e.port*32 +: 32]; gb = bz_a[e.port]; ga = any_a; end
      n_tot++;
      if (gd === e.data && gb === e.busy && ga === e.any) n_pass++;
      else $display("FAIL %s port%0d: got data=%h busy=%b any=%b, want data=%h busy=%b any=%b",
                    e.nm, e.port, gd, gb, ga, e.data, e.busy, e.any);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    reg_write = 1'b0; busy_set = 1'b0; flush = 1'b0;
  endtask

  task automatic rd(int p, int idx);
    read_index[p*5 +: 5] = 5'(idx);
  endtask

  task automatic rd_all(int idx);
    for (int p = 0; p < 4; p++) rd(p, idx);
  endtask

  task automatic wr(int idx, logic [31:0] d);
    reg_write = 1'b1; write_index = 5'(idx); write_data = d;
  endtask

  task automatic bset(int idx);
    busy_set = 1'b1; busy_index = 5'(idx);
  endtask

  task automatic ex(string nm, bit on_b, int p, logic [31:0] d, logic b, logic a);
    exp_t e;
    e.nm = nm; e.on_b = on_b; e.port = p; e.data = d; e.busy = b; e.any = a;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; reg_write = 1'b0; write_index = '0; write_data = '0;
    read_index = '0; busy_set = 1'b0; busy_index = '0; flush = 1'b0;

    @(posedge clk); #1;
    wr(5, 32'hAAAA_AAAA); bset(3); rd_all(5);
    @(posedge clk); #1;
    wr(5, 32'hAAAA_AAAA); bset(3);
    for (int p = 0; p < 4; p++) ex("in_reset", 0, p, 32'h0, 1'b0, 1'b0);
    ex("in_reset_b", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc(); nrst = 1'b1; rd(1, 3);
    ex("post_reset_r5", 0, 0, 32'h0, 1'b0, 1'b0);
    ex("post_reset_r3", 0, 1, 32'h0, 1'b0, 1'b0);
    ex("post_reset_b", 1, 0, 32'h0, 1'b0, 1'b0);

    cyc(); rd_all(5); wr(5, 32'hDEAD_BEEF);
    ex("byp_same", 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    ex("nobyp_same", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    ex("byp_next", 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    ex("nobyp_next", 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc();
    ex("byp_later", 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    ex("nobyp_later", 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    cyc(); rd_all(25); wr(25, 32'h77); bset(25);
    ex("r25_same", 0, 0, 32'h77, 1'b0, 1'b0);
    ex("r25_b_same", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    ex("r25_next", 0, 0, 32'h77, 1'b1, 1'b1);
    ex("r25_b_oor", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc(); wr(25, 32'h78);
    ex("r25_clr", 0, 0, 32'h78, 1'b0, 1'b1);
    ex("r25_b_wr", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    ex("r25_idle", 0, 0, 32'h78, 1'b0, 1'b0);

    cyc(); rd_all(0); wr(0, 32'h1234_5678);
    for (int p = 0; p < 4; p++) ex("r0_wr_same", 0, p, 32'h0, 1'b0, 1'b0);
    cyc();
    for (int p = 0; p < 4; p++) ex("r0_wr_next", 0, p, 32'h0, 1'b0, 1'b0);
    ex("r0_b", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc(); bset(0);
    ex("r0_set_same", 0, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    ex("r0_set_next", 0, 0, 32'h0, 1'b0, 1'b0);
    ex("r0_set_b", 1, 0, 32'h0, 1'b0, 1'b0);

    cyc(); rd_all(7); bset(7);
    ex("r7_set_same", 0, 1, 32'h0, 1'b0, 1'b0);
    cyc();
    ex("r7_set_next", 0, 1, 32'h0, 1'b1, 1'b1);
    ex("r7_set_b", 1, 0, 32'h0, 1'b1, 1'b1);
    cyc(); wr(7, 32'h55);
    ex("r7_wr_byp", 0, 1, 32'h55, 1'b0, 1'b1);
    ex("r7_wr_nobyp", 1, 0, 32'h0, 1'b1, 1'b1);
    cyc();
    ex("r7_after", 0, 1, 32'h55, 1'b0, 1'b0);
    ex("r7_after_b", 1, 0, 32'h55, 1'b0, 1'b0);

    cyc(); rd_all(9); wr(9, 32'h99); bset(9);
    ex("r9_same", 0, 2, 32'h99, 1'b0, 1'b0);
    ex("r9_same_b", 1, 0, 32'h0, 1'b0, 1'b0);
    cyc();
    ex("r9_next", 0, 2, 32'h99, 1'b1, 1'b1);
    ex("r9_next_b", 1, 0, 32'h99, 1'b1, 1'b1);
    cyc(); wr(9, 32'h9A);
    ex("r9_clr", 0, 2, 32'h9A, 1'b0, 1'b1);
    ex("r9_clr_b", 1, 0, 32'h99, 1'b1, 1'b1);
    cyc();
    ex("r9_idle", 0, 2, 32'h9A, 1'b0, 1'b0);
    ex("r9_idle_b", 1, 0, 32'h9A, 1'b0, 1'b0);

    cyc(); bset(3);
    cyc(); bset(4);
    cyc(); bset(6);
    cyc(); rd(0, 3); rd(1, 4); rd(2, 6); rd(3, 10);
    ex("pre_r3", 0, 0, 32'h0, 1'b1, 1'b1);
    ex("pre_r4", 0, 1, 32'h0, 1'b1, 1'b1);
    ex("pre_r6", 0, 2, 32'h0, 1'b1, 1'b1);
    ex("pre_r10", 0, 3, 32'h0, 1'b0, 1'b1);
    ex("pre_b_r3", 1, 0, 32'h0, 1'b1, 1'b1);
    cyc(); flush = 1'b1; bset(10); wr(11, 32'hBB);
    ex("fl_same_r3", 0, 0, 32'h0, 1'b1, 1'b1);
    ex("fl_same_r10", 0, 3, 32'h0, 1'b0, 1'b1);
    cyc();
    ex("fl_r3", 0, 0, 32'h0, 1'b0, 1'b1);
    ex("fl_r4", 0, 1, 32'h0, 1'b0, 1'b1);
    ex("fl_r6", 0, 2, 32'h0, 1'b0, 1'b1);
    ex("fl_r10", 0, 3, 32'h0, 1'b1, 1'b1);
    ex("fl_b_r3", 1, 0, 32'h0, 1'b0, 1'b1);
    cyc(); rd(0, 11);
    ex("fl_wr_r11", 0, 0, 32'hBB, 1'b0, 1'b1);
    ex("fl_wr_r11_b", 1, 0, 32'hBB, 1'b0, 1'b1);

    cyc(); wr(1, 32'h11);
    cyc(); wr(2, 32'h22);
    cyc(); wr(31, 32'h3131); rd(0, 1); rd(1, 1); rd(2, 2); rd(3, 31);
    ex("mp_r1a", 0, 0, 32'h11, 1'b0, 1'b1);
    ex("mp_r1b", 0, 1, 32'h11, 1'b0, 1'b1);
    ex("mp_r2", 0, 2, 32'h22, 1'b0, 1'b1);
    ex("mp_r31_byp", 0, 3, 32'h3131, 1'b0, 1'b1);
    cyc();
    ex("mp_r1a_n", 0, 0, 32'h11, 1'b0, 1'b1);
    ex("mp_r1b_n", 0, 1, 32'h11, 1'b0, 1'b1);
    ex("mp_r2_n", 0, 2, 32'h22, 1'b0, 1'b1);
    ex("mp_r31_n", 0, 3, 32'h3131, 1'b0, 1'b1);
    ex("mp_b_r1", 1, 0, 32'h11, 1'b0, 1'b1);

    cyc(); cyc();
    if (n_tot < 12) $display("FAIL only %0d checks ran", n_tot);
    if (n_pass != n_tot) $display("FAIL %0d of %0d checks failed", n_tot - n_pass, n_tot);
    else $display("PASS");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
